// File: rtl/ctrl_video_encoder_pkg.sv
// Shared definitions for the video encoder control register and its
// blank/settle sequencer: default register address, FSM encoding and
// register bit positions.
package ctrl_video_encoder_pkg;

    localparam logic [7:0] REG_ADDR_DEFAULT = 8'hFB;

    // Register bit positions
    localparam int MODE_BIT      = 0;  // requested mode (0 PAL, 1 NTSC)
    localparam int AUTOBLANK_BIT = 1;  // blank/settle around mode changes
    localparam int BUSY_BIT      = 7;  // read-only sequencer busy flag

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_SETTLE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_delay_counter.sv
// Loadable down-counter used to time the blank and settle phases.
// Load wins over decrement; the count holds at zero.
module seq_delay_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: load, else decrement while non-zero, else hold
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/ctrl_video_encoder_seq.sv
// ZXUNO-mapped encoder control register. A mode change with auto-blank
// enabled forces video black, applies the new mode after BLANK_CYCLES,
// and holds black for SETTLE_CYCLES more so the encoder never switches
// standard mid-frame.
module ctrl_video_encoder_seq
    import ctrl_video_encoder_pkg::*;
#(
    parameter logic [7:0] REG_ADDR      = REG_ADDR_DEFAULT,
    parameter logic [7:0] RESET_VAL     = 8'h00,
    parameter int         BLANK_CYCLES  = 16,
    parameter int         SETTLE_CYCLES = 64,
    parameter int         CNT_W         = 16
) (
    input  logic       clk,
    input  logic       poweron_rst,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe,
    output logic       enc_xtal,
    output logic       enc_mode,
    output logic       enc_blank,
    output logic       busy
);

    localparam logic [CNT_W-1:0] BLANK_LOAD  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_e state_q, state_d;
    logic [6:0] shadow_q, shadow_d;
    logic       mode_q, mode_d;
    logic       pending_q, pending_d;

    logic             wr_hit;
    logic             mode_wr_change;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             unused_din;

    assign unused_din = din[BUSY_BIT];

    assign wr_hit = (zxuno_addr == REG_ADDR) && zxuno_regwr;
    // A same-cycle write is visible to the sequencer (shadow bypass)
    assign shadow_d = wr_hit ? din[6:0] : shadow_q;
    assign mode_wr_change = wr_hit && (din[MODE_BIT] != shadow_q[MODE_BIT]);

    seq_delay_counter #(
        .CNT_W(CNT_W)
    ) u_delay (
        .clk_i      (clk),
        .rst_i      (poweron_rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Sequencer next state, applied mode, pending flag and counter control
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        pending_d    = pending_q;
        cnt_load     = 1'b0;
        cnt_load_val = BLANK_LOAD;
        cnt_dec      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_hit && (din[MODE_BIT] != mode_q)) begin
                    if (din[AUTOBLANK_BIT]) begin
                        state_d  = ST_BLANK;
                        cnt_load = 1'b1;
                    end else begin
                        mode_d = din[MODE_BIT];
                    end
                end
            end
            ST_BLANK: begin
                if (cnt_zero) begin
                    mode_d       = shadow_d[MODE_BIT];
                    state_d      = ST_SETTLE;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETTLE_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    pending_d = 1'b0;
                    if ((pending_q || mode_wr_change) &&
                        (shadow_d[MODE_BIT] != mode_q)) begin
                        state_d  = ST_BLANK;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                    if (mode_wr_change) begin
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shadow register, applied mode and pending flag
    always_ff @(posedge clk) begin
        if (poweron_rst) begin
            state_q   <= ST_IDLE;
            shadow_q  <= RESET_VAL[6:0];
            mode_q    <= RESET_VAL[MODE_BIT];
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign enc_blank = busy;
    assign enc_mode  = mode_q;
    assign enc_xtal  = ~mode_q;
    assign oe        = (zxuno_addr == REG_ADDR) && zxuno_regrd;
    assign dout      = {busy, shadow_q};

endmodule

// File: tb/tb_ctrl_video_encoder_seq.sv
// Bench for ctrl_video_encoder_seq with short blank/settle timing.
// A timestamp-based model of the register and sequencer is compared
// against the DUT every cycle; directed sequences pin literal values.
module tb_ctrl_video_encoder_seq;

  localparam int BLANK = 4;
  localparam int SETTLE = 8;
  localparam logic [7:0] ADDR = 8'hFB;

  logic       clk = 1'b0;
  logic       poweron_rst;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd;
  logic       zxuno_regwr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe;
  logic       enc_xtal;
  logic       enc_mode;
  logic       enc_blank;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  ctrl_video_encoder_seq #(
    .REG_ADDR      (ADDR),
    .RESET_VAL     (8'h00),
    .BLANK_CYCLES  (BLANK),
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (16)
  ) dut (
    .clk         (clk),
    .poweron_rst (poweron_rst),
    .zxuno_addr  (zxuno_addr),
    .zxuno_regrd (zxuno_regrd),
    .zxuno_regwr (zxuno_regwr),
    .din         (din),
    .dout        (dout),
    .oe          (oe),
    .enc_xtal    (enc_xtal),
    .enc_mode    (enc_mode),
    .enc_blank   (enc_blank),
    .busy        (busy)
  );

  // ---------------- comparison helper ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A sequence started at edge k applies the mode at k+BLANK and ends at
  // k+BLANK+SETTLE; edges after the apply point and up to the end form
  // the settle window in which mode-changing writes are remembered.
  int         cyc = 0;
  logic [6:0] m_shadow;
  logic       m_mode;
  bit         m_active;
  bit         m_pending;
  int         m_apply_at;
  int         m_end_at;

  always @(posedge clk) begin
    logic       wr;
    logic [6:0] nsh;
    bit         p;
    cyc++;
    wr = zxuno_regwr && (zxuno_addr == ADDR);
    nsh = wr ? din[6:0] : m_shadow;
    if (poweron_rst) begin
      m_shadow = 7'h00;
      m_mode = 1'b0;
      m_active = 0;
      m_pending = 0;
    end else begin
      if (!m_active) begin
        if (wr && (din[0] != m_mode)) begin
          if (din[1]) begin
            m_active = 1;
            m_apply_at = cyc + BLANK;
            m_end_at = cyc + BLANK + SETTLE;
          end else begin
            m_mode = din[0];
          end
        end
      end else if (cyc == m_apply_at) begin
        m_mode = nsh[0];
      end else if (cyc == m_end_at) begin
        p = m_pending || (wr && (din[0] != m_shadow[0]));
        if (p && (nsh[0] != m_mode)) begin
          m_apply_at = cyc + BLANK;
          m_end_at = cyc + BLANK + SETTLE;
        end else begin
          m_active = 0;
        end
        m_pending = 0;
      end else if (cyc > m_apply_at && wr && (din[0] != m_shadow[0])) begin
        m_pending = 1;
      end
      m_shadow = nsh;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      check("enc_mode", {7'h0, enc_mode}, {7'h0, m_mode});
      check("enc_xtal", {7'h0, enc_xtal}, {7'h0, ~m_mode});
      check("enc_blank", {7'h0, enc_blank}, {7'h0, m_active});
      check("busy", {7'h0, busy}, {7'h0, m_active});
      check("oe", {7'h0, oe}, {7'h0, (zxuno_addr == ADDR) && zxuno_regrd});
      if ((zxuno_addr == ADDR) && zxuno_regrd)
        check("dout", dout, {m_active, m_shadow});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    poweron_rst = 1'b0;
    zxuno_regwr = 1'b0;
    zxuno_regrd = 1'b0;
    zxuno_addr = ADDR;
    din = 8'h00;
  endtask

  // Write is sampled at the next edge; returns just after that edge
  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    zxuno_addr = a;
    din = d;
    zxuno_regwr = 1'b1;
    zxuno_regrd = 1'b0;
    tick();
    zxuno_regwr = 1'b0;
    zxuno_addr = ADDR;
  endtask

  task automatic read_check(input string name, input logic [7:0] exp);
    zxuno_addr = ADDR;
    zxuno_regrd = 1'b1;
    #1;
    check({name, "_oe"}, {7'h0, oe}, 8'h01);
    check(name, dout, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    poweron_rst = 1'b1;
    tick();
    tick();
    poweron_rst = 1'b0;
    checking = 1'b1;

    // Reset state
    read_check("rst_dout", 8'h00);
    check("rst_xtal", {7'h0, enc_xtal}, 8'h01);
    check("rst_mode", {7'h0, enc_mode}, 8'h00);
    check("rst_blank", {7'h0, enc_blank}, 8'h00);
    check("rst_busy", {7'h0, busy}, 8'h00);
    zxuno_regrd = 1'b0;

    // Auto-blank mode change: blank from k, mode at k+4, done at k+12
    write_reg(ADDR, 8'h03);
    check("seq_blank_k", {7'h0, enc_blank}, 8'h01);
    read_check("seq_dout", 8'h83);
    zxuno_regrd = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check("seq_mode", {7'h0, enc_mode}, (e >= 4) ? 8'h01 : 8'h00);
      check("seq_blank", {7'h0, enc_blank}, (e < 12) ? 8'h01 : 8'h00);
      check("seq_busy", {7'h0, busy}, (e < 12) ? 8'h01 : 8'h00);
    end

    // Auto-blank off: immediate mode change, never blanks
    write_reg(ADDR, 8'h00);
    check("nb0_mode", {7'h0, enc_mode}, 8'h00);
    write_reg(ADDR, 8'h01);
    check("nb1_mode", {7'h0, enc_mode}, 8'h01);
    for (int e = 0; e < 4; e++) begin
      check("nb1_blank", {7'h0, enc_blank}, 8'h00);
      check("nb1_busy", {7'h0, busy}, 8'h00);
      tick();
    end

    // Change during settle: blank held, mode back at k+16, low at k+24
    write_reg(ADDR, 8'h00);
    write_reg(ADDR, 8'h03);
    for (int e = 1; e <= 24; e++) begin
      if (e == 6) write_reg(ADDR, 8'h02);
      else tick();
      check("pend_blank", {7'h0, enc_blank}, (e < 24) ? 8'h01 : 8'h00);
      check("pend_mode", {7'h0, enc_mode}, (e >= 4 && e < 16) ? 8'h01 : 8'h00);
    end

    // Reset mid-sequence aborts with no residual blank
    write_reg(ADDR, 8'h03);
    tick();
    poweron_rst = 1'b1;
    tick();
    poweron_rst = 1'b0;
    check("abort_blank", {7'h0, enc_blank}, 8'h00);
    check("abort_busy", {7'h0, busy}, 8'h00);
    check("abort_mode", {7'h0, enc_mode}, 8'h00);
    read_check("abort_dout", 8'h00);
    zxuno_regrd = 1'b0;

    // Other address ignored; regrd low gives no oe
    write_reg(8'hFA, 8'h03);
    check("other_busy", {7'h0, busy}, 8'h00);
    check("other_mode", {7'h0, enc_mode}, 8'h00);
    zxuno_addr = ADDR;
    zxuno_regrd = 1'b0;
    #1;
    check("nord_oe", {7'h0, oe}, 8'h00);
    read_check("other_dout", 8'h00);
    zxuno_regrd = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      poweron_rst = ($urandom_range(0, 299) == 0);
      zxuno_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : ADDR;
      zxuno_regwr = ($urandom_range(0, 9) == 0);
      zxuno_regrd = ($urandom_range(0, 1) == 1);
      din = 8'($urandom_range(0, 255));
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 40; i++) tick();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
